// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with branch, stall, interrupt/eret and per-program reset vectors
module pc_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int INC = 1,
  parameter int PROG_SEL_WIDTH = 2,
  parameter int PROG_STRIDE = 15,
  parameter logic [31:0] INT_VECTOR = 32'h00000100
) (
  input  logic clock,
  input  logic reset,
  input  logic [PROG_SEL_WIDTH-1:0] program_sel,
  input  logic stall,
  input  logic branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic interrupt,
  input  logic eret,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] epc,
  output logic in_isr
);
  typedef enum logic {RUN, ISR} state_t;
  state_t state = RUN;
  state_t state_n;
  logic [ADDR_WIDTH-1:0] pc_r = '0;
  logic [ADDR_WIDTH-1:0] epc_r = '0;
  logic int_pending = 1'b0;
  logic [ADDR_WIDTH-1:0] pc_n, epc_n, ret_pc, reset_pc;
  logic pend_n, take_int, do_eret;
  // state register: reset loads the selected program's vector and abandons any handler
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r <= reset_pc;
      epc_r <= '0;
      int_pending <= 1'b0;
      state <= RUN;
    end else begin
      pc_r <= pc_n;
      epc_r <= epc_n;
      int_pending <= pend_n;
      state <= state_n;
    end
  end
  // next state: stall > eret > interrupt > branch > sequential; pending latches even while stalled
  always_comb begin
    reset_pc = ADDR_WIDTH'(program_sel) * ADDR_WIDTH'(PROG_STRIDE);
    ret_pc = branch_taken ? branch_target : pc_r + ADDR_WIDTH'(INC);
    do_eret = state == ISR && eret;
    take_int = state == RUN && (int_pending || interrupt);
    pc_n = stall ? pc_r : do_eret ? epc_r : take_int ? ADDR_WIDTH'(INT_VECTOR) : ret_pc;
    epc_n = !stall && !do_eret && take_int ? ret_pc : epc_r;
    state_n = stall ? state : do_eret ? RUN : take_int ? ISR : state;
    pend_n = !stall && take_int ? 1'b0 : int_pending || (interrupt && state == RUN);
  end
  // outputs come straight from registers, no input-to-output path
  always_comb begin
    pc = pc_r;
    epc = epc_r;
    in_isr = state == ISR;
  end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scoreboard bench for pc_unit (default and 8-bit/INC=4 instances)
module tb_pc_unit;
  typedef struct {
    string tag;
    bit w;
    logic [31:0] p;
    logic [31:0] e;
    logic i;
  } exp_t;
  logic clock = 1'b0;
  logic reset, stall, branch_taken, interrupt, eret;
  logic [1:0] program_sel;
  logic [31:0] branch_target;
  logic [31:0] pc, epc;
  logic in_isr;
  logic [7:0] w_pc, w_epc;
  logic w_isr;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  pc_unit u_dut (
    .clock(clock), .reset(reset), .program_sel(program_sel), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .interrupt(interrupt),
    .eret(eret), .pc(pc), .epc(epc), .in_isr(in_isr)
  );
  pc_unit #(.ADDR_WIDTH(8), .INC(4)) u_w (
    .clock(clock), .reset(reset), .program_sel(program_sel), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target[7:0]), .interrupt(interrupt),
    .eret(eret), .pc(w_pc), .epc(w_epc), .in_isr(w_isr)
  );
  always #5 clock = ~clock;
  task automatic expm(input string tag, input logic [31:0] p, input logic [31:0] e, input logic i);
    q.push_back('{tag: tag, w: 1'b0, p: p, e: e, i: i});
  endtask
  task automatic expw(input string tag, input logic [31:0] p, input logic [31:0] e, input logic i);
    q.push_back('{tag: tag, w: 1'b1, p: p, e: e, i: i});
  endtask
  task automatic check();
    exp_t x;
    logic [64:0] obs, want;
    while (q.size() > 0) begin
      x = q.pop_front();
      obs = x.w ? {24'h0, w_pc, 24'h0, w_epc, w_isr} : {pc, epc, in_isr};
      want = {x.p, x.e, x.i};
      total++;
      assert (obs === want) else begin
        bad++;
        $error("FAIL %s observed pc=%h epc=%h isr=%b expected pc=%h epc=%h isr=%b",
               x.tag, obs[64:33], obs[32:1], obs[0], want[64:33], want[32:1], want[0]);
      end
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
    check();
  endtask
  initial begin
    reset = 0; stall = 0; branch_taken = 0; interrupt = 0; eret = 0;
    program_sel = 0; branch_target = 0;
    #1;
    expm("powerup", 0, 0, 0); expw("powerup_w", 0, 0, 0); check();
    reset = 1; program_sel = 1; expm("rst_sel1", 15, 0, 0); tick();
    reset = 0; expm("seq16", 16, 0, 0); tick();
    expm("seq17", 17, 0, 0); tick();
    expm("seq18", 18, 0, 0); tick();
    reset = 1; program_sel = 0; expm("rst_sel0", 0, 0, 0); tick();
    reset = 0; expm("seq1", 1, 0, 0); tick();
    reset = 1; program_sel = 3; expm("rst_sel3", 45, 0, 0); tick();
    reset = 0; expm("seq46", 46, 0, 0); tick();
    branch_taken = 1; branch_target = 20; expm("br20", 20, 0, 0); tick();
    branch_target = 32'h40; stall = 1; expm("stall_br_a", 20, 0, 0); tick();
    expm("stall_br_b", 20, 0, 0); tick();
    stall = 0; expm("br40", 32'h40, 0, 0); tick();
    branch_taken = 0; expm("seq41", 32'h41, 0, 0); tick();
    branch_taken = 1; branch_target = 30; expm("br30", 30, 0, 0); tick();
    branch_taken = 0; interrupt = 1; expm("int_take", 32'h100, 31, 1); tick();
    interrupt = 0; expm("isr101", 32'h101, 31, 1); tick();
    interrupt = 1; expm("isr_nest_ign", 32'h102, 31, 1); tick();
    interrupt = 0; eret = 1; expm("eret", 31, 31, 0); tick();
    eret = 0; expm("after_eret", 32, 31, 0); tick();
    expm("no_pending", 33, 31, 0); tick();
    stall = 1; interrupt = 1; expm("int_stall_a", 33, 31, 0); tick();
    interrupt = 0; expm("int_stall_b", 33, 31, 0); tick();
    stall = 0; expm("int_unstall", 32'h100, 34, 1); tick();
    eret = 1; branch_taken = 1; branch_target = 32'h55; expm("eret_beats_br", 34, 34, 0); tick();
    eret = 0; branch_target = 32'h80; interrupt = 1; expm("int_br", 32'h100, 32'h80, 1); tick();
    branch_taken = 0; interrupt = 0; eret = 1; expm("eret_br", 32'h80, 32'h80, 0); tick();
    eret = 0; branch_taken = 1; branch_target = 50; expm("br50", 50, 32'h80, 0); tick();
    branch_taken = 0; eret = 1; expm("stray_eret", 51, 32'h80, 0); tick();
    eret = 0;
    reset = 1; program_sel = 0; expm("rst_w_m", 0, 0, 0); expw("rst_w", 0, 0, 0); tick();
    reset = 0; branch_taken = 1; branch_target = 32'hFC;
    expm("brfc_m", 32'hFC, 0, 0); expw("brfc_w", 32'hFC, 0, 0); tick();
    branch_taken = 0; expm("seqfd_m", 32'hFD, 0, 0); expw("wrap_w", 0, 0, 0); tick();
    interrupt = 1; expm("int_m", 32'h100, 32'hFE, 1); expw("int_w", 0, 4, 1); tick();
    interrupt = 0; reset = 1; program_sel = 2;
    expm("rst_isr_m", 30, 0, 0); expw("rst_isr_w", 30, 0, 0); tick();
    reset = 0; expm("post_rst_m", 31, 0, 0); expw("post_rst_w", 34, 0, 0); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program counter for the MIPS core and successor to the single-register PC. It generates its own sequential increment, accepts branch/jump redirects, and supports stall. It takes external interrupts into a fixed vector, saving the return address in an EPC register and returning on eret. It has a per-program reset vector table indexed by a program-select input. It sits at the head of the fetch stage and drives the instruction-memory address.

Parameters:
ADDR_WIDTH, 32, width of pc, branch_target and epc
INC, 1, increment added per sequential fetch (1 = word addressing, 4 = byte addressing)
PROG_SEL_WIDTH, 2, width of program_sel; 2**PROG_SEL_WIDTH selectable programs
PROG_STRIDE, 15, reset vector = program_sel * PROG_STRIDE (sel 0 -> 0, sel 1 -> 15, sel 2 -> 30, sel 3 -> 45)
INT_VECTOR, 32'h00000100, interrupt handler entry address (truncated to ADDR_WIDTH)

Ports:
clock  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high reset
program_sel  in  PROG_SEL_WIDTH  selects reset vector; sampled only while reset=1
stall  in  1  hold pc and all state this cycle
branch_taken  in  1  redirect request from execute/decode
branch_target  in  ADDR_WIDTH  redirect address, valid with branch_taken
interrupt  in  1  level interrupt request
eret  in  1  return from interrupt handler
pc  out  ADDR_WIDTH  current fetch address (registered)
epc  out  ADDR_WIDTH  saved return address (registered)
in_isr  out  1  high while executing the handler (state ISR)

Behaviour:
- Reset (reset=1 at posedge): pc <= program_sel*PROG_STRIDE (mod 2**ADDR_WIDTH); epc <= 0; in_isr <= 0; int_pending <= 0; state <= RUN. Reset overrides every other input. Power-up initial values equal the reset values for program_sel=0.
- int_pending: internal flag, set on any posedge where interrupt=1 and in_isr=0. Set even during stall, so requests are never lost while stalled. Cleared when the interrupt is taken. Interrupts arriving while in_isr=1 are ignored (no nesting, no queuing).
- State machine: states RUN and ISR; in_isr = (state==ISR).
- Next-pc priority per non-reset posedge, highest first:
  1. stall=1: pc, epc and state hold; only int_pending may set.
  2. state ISR and eret=1: pc <= epc; state <= RUN.
  3. state RUN and (int_pending=1 or interrupt=1): pc <= INT_VECTOR; epc <= the address that would otherwise have been loaded (branch_target if branch_taken, else pc+INC); state <= ISR; int_pending <= 0.
  4. branch_taken=1: pc <= branch_target.
  5. Otherwise: pc <= pc+INC.
- eret in state RUN has no effect; normal sequencing applies.
- branch_taken together with eret in ISR: eret wins and the branch is dropped.
- Arithmetic: pc+INC is modulo 2**ADDR_WIDTH, so the all-ones address plus INC wraps to the low address with no flag.
- Latency: one cycle from any request to the new pc value; pc is registered with no combinational path from inputs to outputs.
- Reset asserted mid-handler abandons the ISR and clears epc and int_pending.

Test Plan:
1. Program select vectors: reset=1 with program_sel=1 for one edge, then release. Required: pc=15. Following edges: 16, 17, 18. Repeat with program_sel=0 (pc=0) and program_sel=3 (pc=45).
2. Branch vs stall: at pc=20 assert branch_taken with target 0x40 together with stall=1 for 2 cycles. Required: pc stays 20 while stalled. After stall drops with branch still asserted: pc=0x40, then 0x41.
3. Interrupt take and return: at pc=30 pulse interrupt for 1 cycle. Required: next pc=0x100, epc=31, in_isr=1; handler runs 0x101, 0x102. A second interrupt pulse during the handler is ignored. eret -> pc=31, in_isr=0, then 32.
4. Interrupt during stall, and interrupt with branch: pulse interrupt while stall=1. Required: pc holds, and the interrupt is taken on the first unstalled edge (pc=0x100). Separately, interrupt with branch_taken to 0x80. Required: pc=0x100, epc=0x80.
5. Wrap and reset mid-ISR: with ADDR_WIDTH=8 and INC=4, drive pc to 0xFC. Required: next pc=0x00. Enter ISR, then assert reset with program_sel=2. Required: pc=30, epc=0, in_isr=0, no pending interrupt.
6. Stray eret: eret=1 in state RUN at pc=50. Required: pc=51, epc unchanged, in_isr=0.
